matrix_slot_writer: RTL and testbench
=====================================

# matrix_slot_writer

Writes one matrix into a slot of the shared matrix BRAM, using the same slot layout the operation selector scans:
- slot `s` starts at `s*BLOCK_SIZE`;
- word 0 is the header `{rows[7:0], cols[7:0], 16'h0000}`;
- elements follow row-major from word 1.

Input elements arrive over a valid/ready stream, typically from the UART/keypad input parser. The header is cleared first and committed last, so a concurrent scan never sees valid dimensions over partially written data.

## Interface
- `BLOCK_SIZE`, 1152: words per slot, header included.
- `ADDR_WIDTH`, 14: BRAM address width.
- `DATA_WIDTH`, 32: element/word width.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `slot_id`  in  3  target slot, latched on start.
- `rows`  in  8  row count, latched on start.
- `cols`  in  8  column count, latched on start.
- `abort`  in  1  cancel the current write; honoured in STREAM only.
- `elem_data`  in  DATA_WIDTH  element value.
- `elem_valid`  in  1  `elem_data` is valid.
- `elem_ready`  out  1  writer accepts an element this cycle.
- `bram_we`  out  1  registered write enable.
- `bram_addr`  out  ADDR_WIDTH  registered write address.
- `bram_din`  out  DATA_WIDTH  registered write data.
- `busy`  out  1  high from the cycle after start until done.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse coincident with `done` when the write failed.

## Operation
- States: IDLE, INVALIDATE, STREAM, COMMIT, DONE.
- **IDLE**
  - On `start`, latch `slot_id`, `rows`, `cols`.
  - Compute `base = slot_id*BLOCK_SIZE` (ADDR_WIDTH bits) and `count = rows*cols` (16 bits).
  - If `rows==0`, `cols==0`, or `count > BLOCK_SIZE-1`: set `err_flag` and go to DONE. No BRAM write occurs.
  - Otherwise go to INVALIDATE.
- **INVALIDATE**
  - Write `bram_addr=base`, `bram_din=0`, `bram_we=1` for exactly one cycle.
  - Clear index `idx`, then go to STREAM.
- **STREAM**
  - `elem_ready=1`, decoded from the state register only, with no combinational path from inputs.
  - Each cycle with `elem_valid && elem_ready`:
    - next cycle drives `bram_we=1`, `bram_addr=base+1+idx`, `bram_din=elem_data`;
    - `idx` increments.
  - Acceptance of element `count-1` moves to COMMIT.
  - `abort` (priority over a same-cycle handshake; that element is not accepted) sets `err_flag` and moves to DONE. The header stays zero, so the slot reads empty.
- **COMMIT**
  - Write `bram_addr=base`, `bram_din={rows,cols,16'h0}`, `bram_we=1` for one cycle.
  - Then go to DONE.
- **DONE**
  - `done=1`, `error=err_flag` for one cycle; clear `err_flag`; return to IDLE.
- `start` outside IDLE is ignored. `abort` outside STREAM is ignored.
- Elements after the last one are not accepted (`elem_ready=0`).

## Timing
- Reset values: `elem_ready=0`, `bram_we=0`, `bram_addr=0`, `bram_din=0`, `busy=0`, `done=0`, `error=0`; state IDLE; `err_flag=0`.
- Reset mid-operation:
  - the writer halts immediately, with no further writes;
  - if INVALIDATE had completed, the header remains 0;
  - otherwise the previous header remains.
- `bram_we` is high only in the cycle after INVALIDATE, after each accepted element, and after COMMIT; it is low otherwise.
- Valid write with back-to-back valid input, `start` at cycle 0:
  - INVALIDATE at cycle 1;
  - STREAM cycles 2..`count+1`;
  - COMMIT at `count+2`;
  - `done` at `count+3`;
  - header write visible on the bus at `count+3`.
- Latency is `count+3` cycles plus stall cycles (`elem_valid` low).
- Invalid dimensions: `done` and `error` high at cycle 2 (IDLE→DONE→pulse).
- `busy` is high from cycle 1 through the DONE cycle and low the cycle after.
- A new `start` is accepted the cycle after `done`.
- Maximum address is `7*1152+1151 = 9215`, which fits 14 bits; no wrap-around.

## Structure
- Shared package `matrix_pkg`:
  - `BLOCK_SIZE`, `NUM_SLOTS=8`;
  - header field positions (`ROWS_MSB=31`, `ROWS_LSB=24`, `COLS_MSB=23`, `COLS_LSB=16`);
  - a `matrix_header_t` packed struct.
  - The scanner and this writer both use these.
- The state enum stays local.
- No sub-module; the single FSM with its address counter is natural.

## Test plan
- Slot 2, 3×4, continuous valid, data 1..12:
  - writes 0 to addr 2304;
  - writes elements 1..12 to addrs 2305..2316;
  - writes header 0x0304_0000 to 2304;
  - `done` at cycle 15, `error=0`.
- Slot 0, 2×2 with `elem_valid` toggled every other cycle: exactly 4 element writes, addresses 1..4 in order, `done` delayed by the stall cycles.
- Invalid requests, each giving `done`+`error` at cycle 2 with `bram_we` never asserted:
  - `rows=0`;
  - `rows=40, cols=40` (1600 > 1151).
- Slot 7, 5×5, `abort` after 3 elements:
  - addr 8064 written 0;
  - addrs 8065..8067 written;
  - no header commit;
  - `done`+`error` pulse.
- Reset asserted during STREAM: all outputs 0 asynchronously; subsequent 1×1 write to slot 1 completes normally with header 0x0101_0000 at 1152.
- `start` pulsed while busy: ignored; exactly one transaction's writes observed.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared matrix BRAM slot layout: slot geometry and header word format used by
// the operation-selector scanner and the slot writer.
package matrix_pkg;

  localparam int BLOCK_SIZE = 1152;
  localparam int NUM_SLOTS  = 8;

  localparam int ROWS_MSB = 31;
  localparam int ROWS_LSB = 24;
  localparam int COLS_MSB = 23;
  localparam int COLS_LSB = 16;

  typedef struct packed {
    logic [ROWS_MSB-ROWS_LSB:0] rows;
    logic [COLS_MSB-COLS_LSB:0] cols;
    logic [COLS_LSB-1:0]        rsvd;
  } matrix_header_t;

  function automatic matrix_header_t make_header(input logic [7:0] r, input logic [7:0] c);
    matrix_header_t h;
    h.rows = r;
    h.cols = c;
    h.rsvd = '0;
    return h;
  endfunction

endpackage

// File: rtl/matrix_slot_writer.sv
// Streams one matrix into a BRAM slot: clears the header, writes elements
// row-major from word 1, then commits the header last.
module matrix_slot_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            slot_id,
  input  logic [7:0]            rows,
  input  logic [7:0]            cols,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] elem_data,
  input  logic                  elem_valid,
  output logic                  elem_ready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);
  import matrix_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INVALIDATE,
    S_STREAM,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t                state;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           count_q;
  logic [15:0]           idx;
  logic                  err_flag;

  logic [15:0]           req_count;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  req_bad;
  matrix_header_t        hdr;

  always_comb begin
    req_count = 16'(rows) * 16'(cols);
    req_base  = ADDR_WIDTH'(slot_id) * ADDR_WIDTH'(BLOCK_SIZE);
    req_bad   = (rows == 8'd0) || (cols == 8'd0) || (req_count > 16'(BLOCK_SIZE - 1));
  end

  assign hdr       = make_header(rows_q, cols_q);
  assign state_dbg = state;

  // Element stream: a transfer happens on a cycle where elem_valid && elem_ready
  // are both high (and abort is low). The producer holds elem_data while valid
  // is high; ready depends only on the state register, never on valid.
  assign elem_ready = (state == S_STREAM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      base_q    <= '0;
      count_q   <= '0;
      idx       <= '0;
      err_flag  <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rows_q   <= rows;
            cols_q   <= cols;
            base_q   <= req_base;
            count_q  <= req_count;
            err_flag <= req_bad;
            busy     <= 1'b1;
            state    <= S_INVALIDATE;
          end
        end
        // Rejected requests pass through here without writing, which lines the
        // done/error pulse up one cycle after the DONE decision.
        S_INVALIDATE: begin
          if (err_flag) begin
            done  <= 1'b1;
            error <= 1'b1;
            state <= S_DONE;
          end else begin
            bram_we   <= 1'b1;
            bram_addr <= base_q;
            bram_din  <= '0;
            idx       <= '0;
            state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (abort) begin
            err_flag <= 1'b1;
            done     <= 1'b1;
            error    <= 1'b1;
            state    <= S_DONE;
          end else if (elem_valid) begin
            bram_we   <= 1'b1;
            bram_addr <= base_q + ADDR_WIDTH'(idx) + ADDR_WIDTH'(1);
            bram_din  <= elem_data;
            idx       <= idx + 16'd1;
            if (idx == count_q - 16'd1) state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          bram_we   <= 1'b1;
          bram_addr <= base_q;
          bram_din  <= DATA_WIDTH'(hdr);
          done      <= 1'b1;
          error     <= err_flag;
          state     <= S_DONE;
        end
        S_DONE: begin
          err_flag <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_slot_writer.sv
// Randomised bench for matrix_slot_writer: a slot-level reference model pushes
// expected BRAM writes and done pulses; a negedge monitor pops and compares.
module tb_matrix_slot_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  slot_id;
  logic [7:0]  rows;
  logic [7:0]  cols;
  logic        abort;
  logic [31:0] elem_data;
  logic        elem_valid;
  logic        elem_ready;
  logic        bram_we;
  logic [13:0] bram_addr;
  logic [31:0] bram_din;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  matrix_slot_writer dut (
    .clk(clk), .rst(rst), .start(start), .slot_id(slot_id), .rows(rows), .cols(cols),
    .abort(abort), .elem_data(elem_data), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .busy(busy),
    .done(done), .error(error), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [45:0] exp_q[$];   // {addr, data}
  logic [33:0] done_q[$];  // {error, cycle_valid, cycle}
  logic [31:0] model_mem[int];
  logic [31:0] obs_mem[int];
  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  bit busy_after_done = 0;
  logic [45:0] e;
  logic [33:0] d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy_after_done) begin
        check("busy_low_after_done", 64'(busy), 64'd0);
        busy_after_done = 0;
      end
      if (bram_we) begin
        obs_mem[int'(bram_addr)] = bram_din;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, none required", bram_addr, bram_din);
        end else begin
          e = exp_q.pop_front();
          check("bram_write", 64'({bram_addr, bram_din}), 64'(e));
        end
      end
      if (done) begin
        done_seen++;
        check("busy_at_done", 64'(busy), 64'd1);
        busy_after_done = 1;
        if (done_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: error=%0b at cycle %0d, no done required", error, cyc);
        end else begin
          d = done_q.pop_front();
          check("done_error", 64'(error), 64'(d[33]));
          if (d[32]) check("done_cycle", 64'(cyc), 64'(d[31:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // mode: 0 continuous random data, 1 valid toggling, 2 random valid, 3 continuous data 1..n
  task automatic run_write(input int slot, input int nr, input int nc, input int mode,
                           input int abort_after, input int reset_after, input bit stray);
    int cnt, base, i, stalls, budget, done_before, start_cyc, n;
    bit ok, aborted, reset_hit, tog;
    logic [31:0] dv;
    cnt  = nr * nc;
    base = slot * 1152;
    ok   = (nr != 0) && (nc != 0) && (cnt <= 1151);
    done_before = done_seen;
    @(posedge clk); #1;
    start = 1'b1; slot_id = 3'(slot); rows = 8'(nr); cols = 8'(nc);
    start_cyc = cyc;
    if (!ok) done_q.push_back({1'b1, 1'b1, 32'(start_cyc + 2)});
    else begin
      exp_q.push_back({14'(base), 32'h0});
      model_mem[base] = 32'h0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (ok) begin
      i = 0; stalls = 0; aborted = 0; reset_hit = 0; tog = 1; budget = 0;
      while (i < cnt && !aborted && !reset_hit && budget < 5000) begin
        elem_valid = 1'b0;
        if (elem_ready) begin
          if (i == reset_after) begin
            rst = 1'b1;
            #1;
            check("async_reset_outputs", 64'({elem_ready, bram_we, bram_addr, bram_din, busy, done, error}), 64'd0);
            exp_q.delete();
            done_q.delete();
            reset_hit = 1;
          end else if (i == abort_after) begin
            abort = 1'b1; elem_valid = 1'b1; elem_data = $urandom;
            aborted = 1;
            done_q.push_back({1'b1, 1'b0, 32'h0});
          end else begin
            case (mode)
              0, 3:    elem_valid = 1'b1;
              1:       elem_valid = tog;
              default: elem_valid = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            dv = (mode == 3) ? 32'(i + 1) : $urandom;
            elem_data = dv;
            if (elem_valid) begin
              exp_q.push_back({14'(base + 1 + i), dv});
              model_mem[base + 1 + i] = dv;
              i++;
            end else stalls++;
            if (stray && i == 2) begin
              start = 1'b1; slot_id = 3'd5; rows = 8'd1; cols = 8'd1;
            end
          end
        end
        if (!reset_hit) begin
          @(posedge clk); #1;
          abort = 1'b0; start = 1'b0; budget++;
        end
      end
      if (budget >= 5000) begin
        n_checks++;
        $display("FAIL stream_budget: %0d of %0d elements accepted", i, cnt);
      end
      if (reset_hit) begin
        elem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (!aborted) begin
        dv = (32'(nr) << 24) | (32'(nc) << 16);
        exp_q.push_back({14'(base), dv});
        model_mem[base] = dv;
        done_q.push_back({1'b0, 1'b1, 32'(start_cyc + cnt + 3 + stalls)});
      end
    end
    n = 0;
    while (done_seen == done_before && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4000) begin
      n_checks++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
    @(posedge clk); #1;
    elem_valid = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; slot_id = '0; rows = '0; cols = '0;
    abort = 1'b0; elem_data = '0; elem_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({elem_ready, bram_we, bram_addr, bram_din, busy, done, error}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_write(2, 3, 4, 3, -1, -1, 0);    // data 1..12, done at cycle 15
    run_write(0, 2, 2, 1, -1, -1, 0);    // valid toggling
    run_write(1, 0, 5, 0, -1, -1, 0);    // rows == 0
    run_write(3, 40, 40, 0, -1, -1, 0);  // 1600 elements
    run_write(6, 36, 32, 0, -1, -1, 0);  // exactly BLOCK_SIZE elements
    run_write(7, 5, 5, 0, 3, -1, 0);     // abort after 3
    run_write(3, 4, 4, 0, -1, 5, 0);     // reset mid-stream
    run_write(1, 1, 1, 0, -1, -1, 0);
    run_write(4, 3, 3, 0, -1, -1, 1);    // stray start while busy
    run_write(7, 47, 24, 0, -1, -1, 0);  // 1128 elements, top of address space
    for (int k = 0; k < 8; k++) begin
      run_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                int'($urandom_range(1, 6)), 2, -1, -1, 0);
    end

    repeat (4) @(posedge clk);
    foreach (model_mem[a]) begin
      if (a % 1152 == 0)
        check("slot_header", 64'(obs_mem.exists(a) ? obs_mem[a] : 32'hdead_beef), 64'(model_mem[a]));
    end
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
